// File: rtl/sum4_pkg.sv
// Shared widths, FSM encoding and delay-line entry format for the
// sum4 adder self-test traffic source / checker.
package sum4_pkg;

   localparam int OPW   = 6;
   localparam int SUMW  = 8;
   localparam int LFSRW = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic            valid;
      logic [7:0]      idx;
      logic [SUMW-1:0] exp;
   } dl_entry_t;

endpackage

// File: rtl/sum4_pipe_tester_lfsr24.sv
// 24-bit Fibonacci LFSR, taps x^24+x^23+x^22+x^17+1.
// load has priority over enable; reset and load both restore SEED.
module lfsr24
   import sum4_pkg::*;
#(
   parameter logic [LFSRW-1:0] SEED = 24'h5A3C96
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enable,
   output logic [LFSRW-1:0] state
);

   logic [LFSRW-1:0] lfsr_q;
   logic [LFSRW-1:0] lfsr_d;
   logic             fb;

   always_comb begin
      fb     = lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16];
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = SEED;
      end else if (enable) begin
         lfsr_d = {lfsr_q[LFSRW-2:0], fb};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state = lfsr_q;

endmodule

// File: rtl/sum4_pipe_tester.sv
// Drives pseudo-random operand sets into the 4-operand adder and checks
// its result against a latency-matched expected-sum delay line.
module sum4_pipe_tester
   import sum4_pkg::*;
#(
   parameter int               NUM_VECTORS = 64,
   parameter int               DUT_LAT     = 4,
   parameter logic [LFSRW-1:0] SEED        = 24'h5A3C96
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [OPW-1:0]  a,
   output logic [OPW-1:0]  b,
   output logic [OPW-1:0]  c,
   output logic [OPW-1:0]  d,
   input  logic [SUMW-1:0] y,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [7:0]      err_count,
   output logic [7:0]      first_err_idx
);

   localparam logic [7:0] NV8  = 8'(NUM_VECTORS);
   localparam logic [7:0] LAT8 = 8'(DUT_LAT);

   state_t          state_q, state_d;
   logic [7:0]      idx_q, idx_d;
   logic [7:0]      drain_q, drain_d;
   logic [7:0]      err_q, err_d;
   logic [7:0]      first_q, first_d;
   logic            pass_q, pass_d;
   logic [OPW-1:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   dl_entry_t       dl_q [DUT_LAT+1];
   dl_entry_t       dl_d [DUT_LAT+1];

   logic            launch;
   logic [7:0]      launch_idx;
   logic [LFSRW-1:0] lfsr_state;
   dl_entry_t       dl_out;

   // The LFSR sits at SEED whenever it is not stepping, so the launch at
   // the start-accept edge already uses SEED with no extra cycle.
   lfsr24 #(.SEED(SEED)) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .load   (!launch),
      .enable (launch),
      .state  (lfsr_state)
   );

   assign dl_out = dl_q[DUT_LAT];

   // Next-state process; checker update first, start-accept clear overrides it.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      drain_d    = drain_q;
      err_d      = err_q;
      first_d    = first_q;
      pass_d     = pass_q;
      launch     = 1'b0;
      launch_idx = idx_q;

      if (dl_out.valid && (y != dl_out.exp)) begin
         if (err_q != 8'hFF) err_d = err_q + 8'd1;
         if (err_q == 8'd0)  first_d = dl_out.idx;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               launch     = 1'b1;
               launch_idx = 8'd0;
               idx_d      = 8'd1;
               drain_d    = 8'd0;
               err_d      = 8'd0;
               first_d    = 8'd0;
               pass_d     = 1'b0;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            if (idx_q == NV8) begin
               drain_d = 8'd0;
               state_d = ST_DRAIN;
            end else begin
               launch = 1'b1;
               idx_d  = idx_q + 8'd1;
            end
         end
         ST_DRAIN: begin
            if (drain_q == LAT8) begin
               pass_d  = (err_d == 8'd0);
               state_d = ST_DONE;
            end else begin
               drain_d = drain_q + 8'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      a_d = launch ? lfsr_state[5:0]   : '0;
      b_d = launch ? lfsr_state[11:6]  : '0;
      c_d = launch ? lfsr_state[17:12] : '0;
      d_d = launch ? lfsr_state[23:18] : '0;
      dl_d[0].valid = launch;
      dl_d[0].idx   = launch_idx;
      dl_d[0].exp   = SUMW'(a_d) + SUMW'(b_d) + SUMW'(c_d) + SUMW'(d_d);
      for (int i = 1; i <= DUT_LAT; i++) begin
         dl_d[i] = dl_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         drain_q <= '0;
         err_q   <= '0;
         first_q <= '0;
         pass_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         for (int i = 0; i <= DUT_LAT; i++) begin
            dl_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         drain_q <= drain_d;
         err_q   <= err_d;
         first_q <= first_d;
         pass_q  <= pass_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         for (int i = 0; i <= DUT_LAT; i++) begin
            dl_q[i] <= dl_d[i];
         end
      end
   end

   // Output decode process.
   always_comb begin
      busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      done = (state_q == ST_DONE);
   end

   assign a             = a_q;
   assign b             = b_q;
   assign c             = c_q;
   assign d             = d_q;
   assign pass          = pass_q;
   assign err_count     = err_q;
   assign first_err_idx = first_q;

endmodule

// File: tb/tb_sum4_pipe_tester.sv
// Directed bench: a 4-stage golden adder model closes the loop, with
// modes to force y to zero or corrupt a single vector's result.
module tb_sum4_pipe_tester;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [5:0] a, b, c, d;
   logic [7:0] y;
   logic       busy, done, pass;
   logic [7:0] err_count, first_err_idx;

   int n_checks = 0;
   int n_errors = 0;
   int mode = 0;          // 0 golden, 1 y forced 0, 2 vector 5 corrupted

   always #5 clk = ~clk;

   sum4_pipe_tester #(.NUM_VECTORS(8), .DUT_LAT(4), .SEED(24'h5A3C96)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .a             (a),
      .b             (b),
      .c             (c),
      .d             (d),
      .y             (y),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .first_err_idx (first_err_idx)
   );

   // Golden adder: four register stages, each tagged with its launch index.
   logic [7:0] s_q [4];
   int         t_q [4];
   int         launch_k;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         launch_k <= 0;
         for (int i = 0; i < 4; i++) begin
            s_q[i] <= '0;
            t_q[i] <= -1;
         end
      end else begin
         launch_k <= (start && !busy && !done) ? 0 : launch_k + 1;
         s_q[0]   <= 8'(a) + 8'(b) + 8'(c) + 8'(d);
         t_q[0]   <= launch_k;
         for (int i = 1; i < 4; i++) begin
            s_q[i] <= s_q[i-1];
            t_q[i] <= t_q[i-1];
         end
      end
   end

   assign y = (mode == 1) ? 8'd0 :
              ((mode == 2) && (t_q[3] == 5)) ? (s_q[3] ^ 8'h01) : s_q[3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Pulse start, check the first launch, then wait (bounded) for done.
   task automatic do_run(input bit extra_starts, output int lat);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("first_a", 32'(a), 22);
      check("first_b", 32'(b), 50);
      check("first_c", 32'(c), 35);
      check("first_d", 32'(d), 22);
      check("busy_run", 32'(busy), 1);
      lat = 1;
      while (!done && lat < 200) begin
         start = (extra_starts && lat == 3);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check("done_seen", 32'(done), 1);
      check("busy_at_done", 32'(busy), 0);
   endtask

   int lat;
   int extra_done;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset only: everything quiet for 20 cycles.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_quiet", {a, b, c, d, busy, done, pass, err_count, first_err_idx}, 0);
      end

      // Golden run.
      mode = 0;
      do_run(1'b0, lat);
      check("done_latency", lat, 14);
      check("golden_pass", 32'(pass), 1);
      check("golden_err", 32'(err_count), 0);
      check("golden_first", 32'(first_err_idx), 0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 0);
      check("pass_held", 32'(pass), 1);

      // y stuck at zero: every vector mismatches.
      mode = 1;
      do_run(1'b0, lat);
      check("zero_err", 32'(err_count), 8);
      check("zero_first", 32'(first_err_idx), 0);
      check("zero_pass", 32'(pass), 0);
      @(negedge clk);

      // Only vector 5 corrupted.
      mode = 2;
      do_run(1'b0, lat);
      check("v5_err", 32'(err_count), 1);
      check("v5_first", 32'(first_err_idx), 5);
      check("v5_pass", 32'(pass), 0);
      @(negedge clk);

      // Reset three cycles into RUN, then a clean golden rerun.
      mode = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      check("busy_before_rst", 32'(busy), 1);
      rst = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_outs", {a, b, c, d, done, pass, err_count, first_err_idx}, 0);
      @(negedge clk); rst = 1'b0;
      do_run(1'b0, lat);
      check("rerun_latency", lat, 14);
      check("rerun_pass", 32'(pass), 1);
      check("rerun_err", 32'(err_count), 0);

      // Extra start pulses during RUN and in the DONE cycle are ignored.
      do_run(1'b1, lat);
      check("extra_latency", lat, 14);
      check("extra_pass", 32'(pass), 1);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("done_start_ignored", 32'(busy), 0);
      extra_done = 0;
      for (int i = 0; i < 20; i++) begin
         if (done || busy) extra_done++;
         @(negedge clk);
      end
      check("no_extra_run", extra_done, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sum4_pipe_tester.md
# sum4_pipe_tester

Self-checking traffic source and checker for the 4-operand pipelined adder (Y = a+b+c+d, 6-bit operands, 8-bit result). On `start` it launches NUM_VECTORS pseudo-random operand sets, one per cycle. It carries a latency-matched expected-sum delay line, compares the adder's Y against it, and reports pass/fail, error count and first failing index. It sits on the adder's input side and consumes its output, closing the loop in board-level self-test.

## Interface
- NUM_VECTORS, 64 — operand sets launched per run (1..255)
- DUT_LAT, 4 — clock edges from the operand-launch edge to the edge at which the adder's Y holds that result
- SEED, 24'h5A3C96 — LFSR reload value at each `start`; must be nonzero
- clk  in  1  — single clock, rising edge
- rst  in  1  — asynchronous, active-high reset
- start  in  1  — one-cycle run request; ignored while busy
- a, b, c, d  out  6 each  — registered operands to the adder
- y  in  8  — adder result
- busy  out  1  — run in progress (RUN or DRAIN)
- done  out  1  — one-cycle pulse at run completion
- pass  out  1  — level, valid from done until next start; 1 iff err_count==0
- err_count  out  8  — mismatches this run, saturates at 255
- first_err_idx  out  8  — vector index of first mismatch; 0 if none

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on start, load LFSR with SEED, clear err_count, first_err_idx, pass, vector index and drain counter, then go to RUN.
- RUN: each cycle, drive a=lfsr[5:0], b=lfsr[11:6], c=lfsr[17:12], d=lfsr[23:18].
  - Push {valid=1, idx, exp=a+b+c+d (8-bit, zero-extended, no overflow possible, max 252)} into the delay line.
  - Step the LFSR (Fibonacci, taps x^24+x^23+x^22+x^17+1).
  - After vector NUM_VECTORS-1, go to DRAIN.
- DRAIN: a..d driven 0; push valid=0 entries; stay DUT_LAT+1 cycles, then go to DONE.
- DONE: one cycle; assert done, set pass=(err_count==0), return to IDLE.
- Delay line depth is DUT_LAT+1, shifting every cycle in all states. At each edge where the outgoing entry is valid:
  - if y != exp, increment err_count (saturating);
  - if this is the first mismatch, latch idx into first_err_idx.
- Invalid entries are never compared.
- start in RUN/DRAIN/DONE is ignored. start in the same cycle as DONE is ignored.

## Timing
- Reset values: a=b=c=d=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, FSM=IDLE, delay-line valid bits 0, LFSR=SEED.
- start sampled at edge E0 → first operands appear after E0, with busy=1 after E0.
- Vector k launches at edge E0+k. Its Y is compared at edge E0+k+DUT_LAT+1.
- Last compare at E0+NUM_VECTORS+DUT_LAT. done is high for the cycle after that, i.e. after edge E0+NUM_VECTORS+DUT_LAT+1. busy falls at the same edge.
- Total run: NUM_VECTORS+DUT_LAT+2 cycles from start sample to done.
- rst mid-run: immediate return to reset values, and in-flight expected entries are discarded. The adder shares rst, so both restart clean.
- err_count saturation: stays at 255, first_err_idx unaffected.
- NUM_VECTORS=1: RUN lasts exactly one cycle.

## Structure
- Package sum4_pkg holds:
  - OPW=6, SUMW=8, LFSRW=24;
  - FSM state enum;
  - delay-line entry typedef {valid, idx[7:0], exp[SUMW-1:0]}.
- Sub-module lfsr24: load, enable, state output; taps fixed.
- FSM, operand registers, delay line and checker live in the top module.

## Test plan
- Reset only, no start → all outputs 0 for 20 cycles; a..d stay 0.
- Golden adder model, DUT_LAT=4, NUM_VECTORS=8, default SEED:
  - first launch a=22, b=50, c=35, d=22, expected 129;
  - done 14 cycles after start sample;
  - pass=1, err_count=0.
- y forced to 0, NUM_VECTORS=8 → err_count=8, first_err_idx=0, pass=0. All expected sums are nonzero.
- Golden model with y corrupted only for vector 5 (y^8'h01) → err_count=1, first_err_idx=5.
- rst asserted 3 cycles into RUN, then start again → busy drops at once, outputs reset, second run matches the golden run exactly (same first vector 22/50/35/22).
- start pulsed again during RUN and in the DONE cycle → ignored; exactly one done pulse per accepted start.
